moore_seq_gen: RTL and testbench
================================

# moore_seq_gen

Serial pattern generator and transmit-side counterpart of the overlapping `1101` Moore sequence detector. On a `start` request it shifts a fixed PAT_LEN-bit pattern out MSB-first, one bit per clock, and repeats it a programmed number of times. It then signals completion. It drives the detector's `in` input in loopback benches and serves as a framing or sync-word source in the datapath.

## Interface
- PATTERN, 4'b1101: transmitted pattern, MSB sent first.
- PAT_LEN, 4: pattern width in bits, 2..16.
- CNT_W, 4: width of the repeat counter.
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- repeat_cnt  in  CNT_W  number of pattern repetitions; latched with `start`.
- abort  in  1  terminate transmission; sampled in SEND and GAP.
- out  out  1  serial data bit; 0 whenever `valid` is 0.
- valid  out  1  `out` carries a pattern bit this cycle.
- busy  out  1  transmission in progress (SEND or GAP).
- done  out  1  one-cycle pulse after the last bit of the last repetition.

## Operation
- Moore FSM with states IDLE, SEND, GAP, DONE.
- All outputs are registered and decoded from state and datapath registers only.
- Reset (`reset`=0 at a rising edge) forces IDLE, `out`=0, `valid`=0, `busy`=0, `done`=0, and clears the bit index and repeat counter. Reset has priority over every other input, including mid-SEND.
- IDLE:
  - `start`=1 and `repeat_cnt`≠0: latch `repeat_cnt` into `rem`, set bit index to PAT_LEN-1, go to SEND.
  - `start`=1 and `repeat_cnt`=0: go directly to DONE; no bits are sent.
- SEND:
  - `out`=PATTERN[idx], `valid`=1, `busy`=1.
  - idx decrements each cycle.
  - At idx=0 with `rem`>1: decrement `rem`, reload idx to PAT_LEN-1, and go to GAP (gap build) or stay in SEND (back-to-back).
  - At idx=0 with `rem`=1: go to DONE.
- GAP (gap build only): exactly one cycle with `out`=0, `valid`=0, `busy`=1, then SEND.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE. `start` in DONE is ignored.
- `abort`=1 in SEND or GAP returns the FSM to IDLE at the next edge. No `done` pulse, the partial pattern is truncated, and `out`/`valid` drop to 0.
- `start` while `busy` is ignored; the latched `repeat_cnt` is never updated mid-transmission.
- `rem` is CNT_W bits wide and never wraps: it is decremented only when `rem`>1.

## Timing
- `start` sampled at edge k:
  - First bit (PATTERN MSB) is visible after edge k, i.e. in cycle k+1.
  - Back-to-back: the last bit is in cycle k+PAT_LEN·R and `done` is high in cycle k+PAT_LEN·R+1.
  - Gap: each repetition boundary adds one cycle, so `done` is high in cycle k+PAT_LEN·R+(R-1)+1.
- `repeat_cnt`=0: `done` is high in cycle k+1.
- Earliest next accepted `start` is the cycle after `done` (IDLE).
- `abort` sampled at edge a: `valid`=0 from cycle a+1.

## Configuration
- Macro `MOORE_SEQ_GEN_GAP_EN`.
- Defined: the GAP state is compiled in, giving one idle cycle between repetitions. A downstream overlapping detector then sees isolated patterns.
- Undefined: the GAP state is absent and repetitions are sent back-to-back.

## Structure
- Shared package `moore_seq_pkg`:
  - state enum (IDLE, SEND, GAP, DONE) with 2-bit encoding;
  - default PATTERN constant 4'b1101;
  - default PAT_LEN;
  - the detector's matching pattern constant, so generator and detector stay consistent.
- One sub-module, `moore_seq_idx_cnt`: down-counter with load and terminal-count flag, used for the bit index.
- The repeat counter stays inline.

## Test plan
- Reset mid-SEND: R=3, assert `reset`=0 at the 2nd bit → next cycle IDLE, `out`/`valid`/`busy`/`done`=0; no `done` afterwards.
- Single pattern: `start`, `repeat_cnt`=1 → `out`=1,1,0,1 with `valid`=1 in cycles k+1..k+4; `done`=1 in cycle k+5 only; `busy`=1 in cycles k+1..k+4.
- Repeat, back-to-back: `repeat_cnt`=3, macro undefined → 12 valid bits 110111011101, `done` in cycle k+13. In loopback the detector pulses 3 times.
- Repeat, gap: same stimulus with `MOORE_SEQ_GEN_GAP_EN` → `valid` drops in cycles k+5 and k+10, `done` in cycle k+15.
- Zero count and ignored start: `repeat_cnt`=0 → `done` in cycle k+1 with no `valid`. A second `start` pulsed during SEND with R=2 has no effect; exactly 8 bits are sent.
- Abort: R=2, `abort` at the 6th bit → `valid`=0 next cycle, FSM in IDLE, no `done`; a fresh `start` two cycles later is accepted.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// Shared types and constants for the 1101 Moore sequence generator/detector pair.
// Keeps the transmitted pattern and the detector's matching pattern in one place.
package moore_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int PAT_LEN_DEF = 4;

   localparam logic [PAT_LEN_DEF-1:0] PATTERN_DEF = 4'b1101;

   // The overlapping detector matches exactly what the generator sends.
   localparam logic [PAT_LEN_DEF-1:0] DET_PATTERN = PATTERN_DEF;

   function automatic int idx_w(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/moore_seq_gen_if.sv
// Request/serial-output bundle between a controller and moore_seq_gen.
// master drives start/repeat_cnt/abort; slave drives the serial stream.
interface moore_seq_gen_if #(
   parameter int CNT_W = 4
);

   logic             start;
   logic [CNT_W-1:0] repeat_cnt;
   logic             abort;
   logic             out;
   logic             valid;
   logic             busy;
   logic             done;

   modport master (
      output start, repeat_cnt, abort,
      input  out, valid, busy, done
   );

   modport slave (
      input  start, repeat_cnt, abort,
      output out, valid, busy, done
   );

endinterface

// File: rtl/moore_seq_idx_cnt.sv
// Bit-index down-counter with load and terminal-count flag.
// nxt exposes the value the counter takes at the coming edge.
module moore_seq_idx_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] nxt,
   output logic         tc
);

   logic [W-1:0] cnt;

   assign nxt = load ? load_val
              : dec  ? cnt - W'(1)
              :        cnt;

   assign tc = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!reset) cnt <= '0;
      else        cnt <= nxt;
   end

endmodule

// File: rtl/moore_seq_gen.sv
// Serial pattern generator: shifts PATTERN MSB-first repeat_cnt times, then pulses done.
// Define MOORE_SEQ_GEN_GAP_EN to insert one idle cycle between repetitions.
module moore_seq_gen
   import moore_seq_pkg::*;
#(
   parameter int                 PAT_LEN = PAT_LEN_DEF,
   parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF,
   parameter int                 CNT_W   = 4
) (
   input  logic                clk,
   input  logic                reset,
   moore_seq_gen_if.slave      bus
);

   localparam int            IW   = idx_w(PAT_LEN);
   localparam logic [IW-1:0] LAST = IW'(PAT_LEN - 1);

`ifdef MOORE_SEQ_GEN_GAP_EN
   localparam state_e REP_ST = GAP;
`else
   localparam state_e REP_ST = SEND;
`endif

   state_e           state, state_n;
   logic [CNT_W-1:0] rem, rem_n;
   logic             idx_load;
   logic             idx_dec;
   logic             idx_tc;
   logic [IW-1:0]    idx_nxt;

   moore_seq_idx_cnt #(.W(IW)) u_idx (
      .clk      (clk),
      .reset    (reset),
      .load     (idx_load),
      .dec      (idx_dec),
      .load_val (LAST),
      .nxt      (idx_nxt),
      .tc       (idx_tc)
   );

   always_comb begin
      state_n  = state;
      rem_n    = rem;
      idx_load = 1'b0;
      idx_dec  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.repeat_cnt != '0) begin
                  rem_n    = bus.repeat_cnt;
                  idx_load = 1'b1;
                  state_n  = SEND;
               end else begin
                  state_n  = DONE;
               end
            end
         end
         SEND: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else if (idx_tc) begin
               // rem only counts down while >1, so it can never wrap.
               if (rem > CNT_W'(1)) begin
                  rem_n    = rem - CNT_W'(1);
                  idx_load = 1'b1;
                  state_n  = REP_ST;
               end else begin
                  state_n  = DONE;
               end
            end else begin
               idx_dec = 1'b1;
            end
         end
         GAP: begin
            state_n = bus.abort ? IDLE : SEND;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         rem       <= '0;
         bus.out   <= 1'b0;
         bus.valid <= 1'b0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
      end else begin
         state     <= state_n;
         rem       <= rem_n;
         bus.out   <= (state_n == SEND) & PATTERN[idx_nxt];
         bus.valid <= (state_n == SEND);
         bus.busy  <= (state_n == SEND) || (state_n == GAP);
         bus.done  <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_moore_seq_gen.sv
// Self-checking bench for moore_seq_gen: directed and random transactions
// checked cycle by cycle against a stream model built from the pattern rules.
module tb_moore_seq_gen;

   localparam int             PLEN = 4;
   localparam logic [PLEN-1:0] PAT = 4'b1101;

`ifdef MOORE_SEQ_GEN_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   typedef logic [3:0] q_t[$];

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   moore_seq_gen_if #(.CNT_W(4)) bus ();

   moore_seq_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input logic [3:0] exp, input string tag);
      logic [3:0] obs;
      obs = {bus.out, bus.valid, bus.busy, bus.done};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs(out,valid,busy,done)=%b exp=%b", tag, obs, exp);
      end
   endtask

   // Expected per-cycle {out,valid,busy,done} from the cycle after start.
   function automatic q_t build(input int r);
      q_t q;
      logic [PLEN-1:0] p;
      p = PAT;
      for (int k = 0; k < r; k++) begin
         for (int b = PLEN - 1; b >= 0; b--)
            q.push_back({p[b], 1'b1, 1'b1, 1'b0});
         if (GAP_EN && k < r - 1)
            q.push_back(4'b0010);
      end
      q.push_back(4'b0001);
      return q;
   endfunction

   function automatic int nth_bit_idx(input q_t q, input int n);
      int c;
      c = 0;
      for (int i = 0; i < q.size(); i++) begin
         if (q[i][2]) begin
            c++;
            if (c == n) return i;
         end
      end
      return -1;
   endfunction

   // kind: 0 none, 1 abort, 2 reset at cycle index kill_at
   task automatic run_txn(input int r, input int ign_at,
                          input int kind, input int kill_at,
                          input string tag);
      q_t  q;
      bit  killed;
      q = build(r);
      killed = 1'b0;
      bus.start      = 1'b1;
      bus.repeat_cnt = 4'(r);
      tick();
      bus.start      = 1'b0;
      bus.repeat_cnt = 4'($urandom_range(1, 15));
      for (int i = 0; i < q.size(); i++) begin
         check(q[i], $sformatf("%s_c%0d", tag, i));
         if (i == ign_at) begin
            bus.start      = 1'b1;
            bus.repeat_cnt = 4'($urandom_range(1, 15));
         end
         if (kind != 0 && i == kill_at) begin
            if (kind == 1) bus.abort = 1'b1;
            else           reset     = 1'b0;
         end
         tick();
         bus.start = 1'b0;
         bus.abort = 1'b0;
         reset     = 1'b1;
         if (kind != 0 && i == kill_at) begin
            killed = 1'b1;
            break;
         end
      end
      check(4'b0000, {tag, "_after"});
      if (killed) begin
         tick();
         check(4'b0000, {tag, "_nodone1"});
         tick();
         check(4'b0000, {tag, "_nodone2"});
      end
   endtask

   initial begin
      q_t q;
      int r, len, ign, kind, kat;
      reset          = 1'b0;
      bus.start      = 1'b1;
      bus.repeat_cnt = 4'd3;
      bus.abort      = 1'b0;
      tick();
      tick();
      check(4'b0000, "reset_state");
      bus.start = 1'b0;
      reset     = 1'b1;
      tick();
      check(4'b0000, "idle");

      run_txn(1, -1, 0, -1, "single");
      run_txn(3, -1, 0, -1, "rep3");
      run_txn(0, -1, 0, -1, "zero");
      run_txn(2, 2, 0, -1, "ign_start");

      q = build(2);
      run_txn(2, -1, 1, nth_bit_idx(q, 6), "abort");
      run_txn(1, -1, 0, -1, "post_abort");

      run_txn(3, -1, 2, 1, "rst_mid");
      run_txn(1, -1, 0, -1, "post_rst");

      for (int t = 0; t < 20; t++) begin
         r    = $urandom_range(0, 6);
         q    = build(r);
         len  = q.size();
         ign  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, len - 1) : -1;
         kind = 0;
         kat  = -1;
         if (r > 0 && $urandom_range(0, 3) == 0) begin
            kind = $urandom_range(1, 2);
            kat  = $urandom_range(0, len - 2);
         end
         run_txn(r, ign, kind, kat, $sformatf("rnd%0d_r%0d", t, r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
